// File: rtl/image_sequencer.sv
// image_sequencer: walks the image/label ROMs, hands each image to the
// network over valid/ready, scores the returned prediction against the
// label and reports the number of correct predictions at the end of a run.
module image_sequencer #(
  parameter int PIXEL_WIDTH = 9,
  parameter int NUM_PIXELS  = 784,
  parameter int IMAGE_WIDTH = PIXEL_WIDTH * NUM_PIXELS,
  parameter int NUM_IMAGES  = 100,
  parameter int LABEL_WIDTH = 4,
  parameter int ROM_LATENCY = 1,
  localparam int AW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int CW = $clog2(NUM_IMAGES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic [AW-1:0]          rom_address,
  input  logic [IMAGE_WIDTH-1:0] rom_image,
  input  logic [LABEL_WIDTH-1:0] rom_label,
  output logic [IMAGE_WIDTH-1:0] image,
  output logic                   image_valid,
  input  logic                   image_ready,
  input  logic [LABEL_WIDTH-1:0] prediction,
  input  logic                   prediction_valid,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          image_index,
  output logic [CW-1:0]          num_correct
);

  // Latency counter must be able to hold ROM_LATENCY itself.
  localparam int LCW = $clog2(ROM_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_WAIT_RESULT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          image_index_q, image_index_d;
  logic [IMAGE_WIDTH-1:0] image_q, image_d;
  logic                   image_valid_q, image_valid_d;
  logic [LABEL_WIDTH-1:0] label_q, label_d;
  logic [CW-1:0]          num_correct_q, num_correct_d;
  logic [LCW-1:0]         lat_cnt_q, lat_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state and next-output logic for the run controller.
  always_comb begin
    state_d       = state_q;
    image_index_d = image_index_q;
    image_d       = image_q;
    image_valid_d = image_valid_q;
    label_d       = label_q;
    num_correct_d = num_correct_q;
    lat_cnt_d     = lat_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_correct_d = '0;
          image_index_d = '0;
          lat_cnt_d     = '0;
          state_d       = S_FETCH;
        end
      end

      // The ROM needs ROM_LATENCY edges after the address settles; its data
      // is captured on the edge after those have elapsed.
      S_FETCH: begin
        if (lat_cnt_q == LCW'(ROM_LATENCY)) begin
          image_d       = rom_image;
          label_d       = rom_label;
          image_valid_d = 1'b1;
          lat_cnt_d     = '0;
          state_d       = S_PRESENT;
        end else begin
          lat_cnt_d = lat_cnt_q + LCW'(1);
        end
      end

      S_PRESENT: begin
        if (image_ready) begin
          image_valid_d = 1'b0;
          state_d       = S_WAIT_RESULT;
        end
      end

      S_WAIT_RESULT: begin
        if (prediction_valid) begin
          if (prediction == label_q) begin
            num_correct_d = num_correct_q + CW'(1);
          end
          if (image_index_q == AW'(NUM_IMAGES - 1)) begin
            state_d = S_DONE;
          end else begin
            image_index_d = image_index_q + AW'(1);
            lat_cnt_d     = '0;
            state_d       = S_FETCH;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      image_index_q <= '0;
      image_q       <= '0;
      image_valid_q <= 1'b0;
      label_q       <= '0;
      num_correct_q <= '0;
      lat_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      image_index_q <= image_index_d;
      image_q       <= image_d;
      image_valid_q <= image_valid_d;
      label_q       <= label_d;
      num_correct_q <= num_correct_d;
      lat_cnt_q     <= lat_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // The ROM address is the image index by construction.
  assign rom_address = image_index_q;
  assign image_index = image_index_q;
  assign image       = image_q;
  assign image_valid = image_valid_q;
  assign num_correct = num_correct_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_image_sequencer.sv
// tb_image_sequencer: randomized runs of image_sequencer against a latency-1
// ROM model (label[i]=i) and a network model with random ready delays,
// wrong answers and ignored stray strobes; expected score counted per run.
module tb_image_sequencer;

  localparam int PW = 9;
  localparam int NP = 8;
  localparam int IW = PW * NP;
  localparam int NI = 4;
  localparam int LW = 4;
  localparam int RL = 1;
  localparam int AW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_address;
  logic [IW-1:0] rom_image;
  logic [LW-1:0] rom_label;
  logic [IW-1:0] image;
  logic          image_valid;
  logic          image_ready = 1'b0;
  logic [LW-1:0] prediction = '0;
  logic          prediction_valid = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] image_index;
  logic [CW-1:0] num_correct;

  logic [IW-1:0] img_mem [NI];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  image_sequencer #(
    .PIXEL_WIDTH(PW),
    .NUM_PIXELS (NP),
    .IMAGE_WIDTH(IW),
    .NUM_IMAGES (NI),
    .LABEL_WIDTH(LW),
    .ROM_LATENCY(RL)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .start           (start),
    .rom_address     (rom_address),
    .rom_image       (rom_image),
    .rom_label       (rom_label),
    .image           (image),
    .image_valid     (image_valid),
    .image_ready     (image_ready),
    .prediction      (prediction),
    .prediction_valid(prediction_valid),
    .busy            (busy),
    .done            (done),
    .image_index     (image_index),
    .num_correct     (num_correct)
  );

  // Synchronous ROMs with one edge of read latency; label[i] = i.
  always @(posedge clk) begin
    rom_image <= img_mem[rom_address];
    rom_label <= LW'(rom_address);
  end

  // Count every cycle in which done is high.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_busy", 128'(busy), 128'(1));
    check_val("start_clear", 128'(num_correct), 128'(0));
    check_val("start_addr", 128'(rom_address), 128'(0));
    $display("run started");
  endtask

  // One run over all images. ready_img gets ready_dly cycles of backpressure,
  // the others a short random delay. noise adds strobes that must be ignored.
  // abort_img >= 0 resets the DUT in WAIT_RESULT of that image.
  // chain asserts start during DONE and in the following IDLE cycle.
  task automatic do_images(input int wrong_mask, input int ready_dly, input int ready_img,
                           input bit noise, input int abort_img, input bit chain);
    int exp_ok;
    int d0;
    int n;
    int dly;
    int w;
    bit wrong;
    exp_ok = 0;
    d0 = done_cnt;
    for (int i = 0; i < NI; i++) begin
      n = 0;
      while (image_valid !== 1'b1 && n < 20) begin
        if (noise) begin
          prediction_valid = 1'b1;
          prediction = LW'(i);
        end
        tick();
        prediction_valid = 1'b0;
        n++;
      end
      check_val("fetch_latency", 128'(n), 128'(RL + 1));
      check_val("rom_address", 128'(rom_address), 128'(i));
      check_val("image_index", 128'(image_index), 128'(i));
      check_val("image_data", 128'(image), 128'(img_mem[i]));

      dly = (i == ready_img) ? ready_dly : int'($urandom_range(0, 2));
      for (int k = 0; k < dly; k++) begin
        if (noise && ($urandom_range(0, 1) == 1)) begin
          prediction_valid = 1'b1;
          prediction = LW'(i);
        end
        tick();
        prediction_valid = 1'b0;
        check_val("hold_valid", 128'(image_valid), 128'(1));
        check_val("hold_image", 128'(image), 128'(img_mem[i]));
        check_val("hold_addr", 128'(rom_address), 128'(i));
      end

      image_ready = 1'b1;
      if (noise) begin
        prediction_valid = 1'b1;
        prediction = LW'(i);
      end
      tick();
      image_ready = 1'b0;
      prediction_valid = 1'b0;
      check_val("accept_valid", 128'(image_valid), 128'(0));
      check_val("accept_busy", 128'(busy), 128'(1));

      if (i == abort_img) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_busy", 128'(busy), 128'(0));
        check_val("abort_count", 128'(num_correct), 128'(0));
        check_val("abort_addr", 128'(rom_address), 128'(0));
        check_val("abort_valid", 128'(image_valid), 128'(0));
        check_val("abort_done", 128'(done), 128'(0));
        for (int k = 0; k < 3; k++) tick();
        check_val("abort_no_done", 128'(done_cnt - d0), 128'(0));
        $display("run aborted at image %0d", i);
        return;
      end

      w = int'($urandom_range(0, 3));
      for (int k = 0; k < w; k++) begin
        if (noise) start = 1'b1;
        tick();
        start = 1'b0;
        check_val("wait_addr", 128'(rom_address), 128'(i));
        check_val("wait_busy", 128'(busy), 128'(1));
      end

      wrong = wrong_mask[i];
      prediction_valid = 1'b1;
      if (wrong) prediction = LW'(i + 1 + int'($urandom_range(0, 14)));
      else begin
        prediction = LW'(i);
        exp_ok++;
      end
      tick();
      prediction_valid = 1'b0;
    end

    check_val("done_pulse", 128'(done), 128'(1));
    check_val("done_busy", 128'(busy), 128'(1));
    check_val("num_correct", 128'(num_correct), 128'(exp_ok));

    if (chain) start = 1'b1;
    tick();
    check_val("post_done", 128'(done), 128'(0));
    check_val("post_busy", 128'(busy), 128'(0));
    check_val("held_count", 128'(num_correct), 128'(exp_ok));
    if (chain) begin
      tick();
      start = 1'b0;
      check_val("chain_busy", 128'(busy), 128'(1));
      check_val("chain_clear", 128'(num_correct), 128'(0));
    end else begin
      tick();
      check_val("idle_busy", 128'(busy), 128'(0));
    end
    check_val("done_count", 128'(done_cnt - d0), 128'(1));
    $display("run complete: mask=%0h expected correct=%0d got=%0d", wrong_mask, exp_ok, num_correct);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      img_mem[i] = IW'({$urandom(), $urandom(), $urandom()});
    end

    reset = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b0;
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_done", 128'(done), 128'(0));
    check_val("rst_valid", 128'(image_valid), 128'(0));
    check_val("rst_addr", 128'(rom_address), 128'(0));
    check_val("rst_index", 128'(image_index), 128'(0));
    check_val("rst_image", 128'(image), 128'(0));
    check_val("rst_count", 128'(num_correct), 128'(0));
    $display("reset state checked");

    // All correct.
    start_run();
    do_images(0, 0, -1, 1'b0, -1, 1'b0);
    // Wrong on images 1 and 3.
    start_run();
    do_images(32'b1010, 0, -1, 1'b0, -1, 1'b0);
    // Long backpressure on image 2.
    start_run();
    do_images(0, 10, 2, 1'b0, -1, 1'b0);
    // Stray start / prediction strobes.
    start_run();
    do_images(0, 3, 1, 1'b1, -1, 1'b0);
    // Reset in WAIT_RESULT of image 2, then a fresh run chained into another.
    start_run();
    do_images(0, 0, -1, 1'b0, 2, 1'b0);
    start_run();
    do_images(0, 0, -1, 1'b0, -1, 1'b1);
    do_images(int'($urandom_range(0, 15)), 0, -1, 1'b1, -1, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      start_run();
      do_images(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, NI - 1)), 1'($urandom_range(0, 1)), -1,
                1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
